// File: rtl/se_weight_loader_if.sv
// Bus bundle for se_weight_loader: weight ROM read port, upstream pixel
// stream and the SE-module kernel-load/data inputs.
interface se_weight_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  rom_rd_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] pix_in_data;
    logic                  pix_in_valid;
    logic                  pix_in_ready;
    logic [DATA_WIDTH-1:0] se_in_data;
    logic                  se_input_valid;
    logic                  se_load_kernel_conv1;
    logic                  se_load_kernel_conv2;

    modport master (
        output rom_rd_en, rom_addr,
        input  rom_data,
        input  pix_in_data, pix_in_valid,
        output pix_in_ready,
        output se_in_data, se_input_valid,
        output se_load_kernel_conv1, se_load_kernel_conv2
    );

    modport slave (
        input  rom_rd_en, rom_addr,
        output rom_data,
        output pix_in_data, pix_in_valid,
        input  pix_in_ready,
        input  se_in_data, se_input_valid,
        input  se_load_kernel_conv1, se_load_kernel_conv2
    );
endinterface

// File: rtl/se_weight_loader.sv
// Streams Conv1 then Conv2 1x1 weights from a synchronous ROM into the SE
// block with setup/hold/gap framing, then muxes the pixel stream through.
module se_weight_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int IN_CHANNELS = 16,
    parameter int REDUCTION   = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    se_weight_loader_if.master  bus,
    output logic                busy,
    output logic                done
);
    localparam int N  = IN_CHANNELS * (IN_CHANNELS / REDUCTION);
    localparam int CW = $clog2(N) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    if ((2 ** ADDR_WIDTH) < (2 * N)) begin : g_addr_chk
        $error("se_weight_loader: ADDR_WIDTH too small for 2*N weights");
    end
    if (GAP_CYCLES < 1) begin : g_gap_chk
        $error("se_weight_loader: GAP_CYCLES must be >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, SETUP1, STREAM1, HOLD1, GAP, SETUP2, STREAM2, HOLD2, DONE, PASS
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [GW-1:0]         gap_cnt, gap_cnt_next;
    logic                  rd_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  conv1_q, conv2_q, ready_q, busy_q, done_q;
    logic                  in_stream, in_pass;

    // Next-state sequencing; counters run only while staying in STREAM/GAP
    always_comb begin
        state_next   = state;
        cnt_next     = '0;
        gap_cnt_next = '0;
        unique case (state)
            IDLE:    if (start) state_next = SETUP1;
            SETUP1:  state_next = STREAM1;
            STREAM1: begin
                if (cnt == CW'(N - 1)) state_next = HOLD1;
                else                   cnt_next   = cnt + CW'(1);
            end
            HOLD1:   state_next = GAP;
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) state_next   = SETUP2;
                else                                gap_cnt_next = gap_cnt + GW'(1);
            end
            SETUP2:  state_next = STREAM2;
            STREAM2: begin
                if (cnt == CW'(N - 1)) state_next = HOLD2;
                else                   cnt_next   = cnt + CW'(1);
            end
            HOLD2:   state_next = DONE;
            DONE:    state_next = PASS;
            PASS:    if (start) state_next = SETUP1;
            default: state_next = IDLE;
        endcase
    end

    // ROM prefetch: issue the address one cycle before its word is presented
    always_comb begin
        rd_next   = 1'b0;
        addr_next = addr_q;
        case (state_next)
            SETUP1: begin
                rd_next   = 1'b1;
                addr_next = '0;
            end
            SETUP2: begin
                rd_next   = 1'b1;
                addr_next = ADDR_WIDTH'(N);
            end
            STREAM1: begin
                if (cnt_next < CW'(N - 1)) begin
                    rd_next   = 1'b1;
                    addr_next = ADDR_WIDTH'(cnt_next) + ADDR_WIDTH'(1);
                end
            end
            STREAM2: begin
                if (cnt_next < CW'(N - 1)) begin
                    rd_next   = 1'b1;
                    addr_next = ADDR_WIDTH'(N) + ADDR_WIDTH'(cnt_next) + ADDR_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    // State, counters and next-state-registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            conv1_q <= 1'b0;
            conv2_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            gap_cnt <= gap_cnt_next;
            rd_q    <= rd_next;
            addr_q  <= addr_next;
            conv1_q <= (state_next == SETUP1) || (state_next == STREAM1) || (state_next == HOLD1);
            conv2_q <= (state_next == SETUP2) || (state_next == STREAM2) || (state_next == HOLD2);
            ready_q <= (state_next == PASS);
            busy_q  <= (state_next != IDLE) && (state_next != DONE) && (state_next != PASS);
            done_q  <= (state_next == DONE);
        end
    end

    // Data/valid mux: ROM word while streaming, raw pixel path in PASS
    always_comb begin
        in_stream          = (state == STREAM1) || (state == STREAM2);
        in_pass            = (state == PASS);
        bus.se_in_data     = '0;
        bus.se_input_valid = 1'b0;
        if (in_stream) begin
            bus.se_in_data     = bus.rom_data;
            bus.se_input_valid = 1'b1;
        end else if (in_pass) begin
            bus.se_in_data     = bus.pix_in_data;
            bus.se_input_valid = bus.pix_in_valid;
        end
    end

    assign bus.rom_rd_en            = rd_q;
    assign bus.rom_addr             = addr_q;
    assign bus.pix_in_ready         = ready_q;
    assign bus.se_load_kernel_conv1 = conv1_q;
    assign bus.se_load_kernel_conv2 = conv2_q;
    assign busy                     = busy_q;
    assign done                     = done_q;
endmodule
